sensor_delta_monitor: RTL and testbench

Multi-channel successor to the single-sensor change detector. Accepts tagged samples of DW bits on a time-multiplexed input and keeps one stored baseline per channel. When a sample differs from its channel's baseline by more than THRESH, the block updates the baseline and pushes a change event (channel, new value, delta) into a small event FIFO. The FIFO is drained by the downstream LED/interrupt logic through a valid/ready handshake.

---
 rtl/sensor_delta_monitor.sv | 244 ++++++++++++++++++++++++
 tb/tb_sensor_delta_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_delta_monitor.sv
// sensor_delta_monitor
//   Multi-channel sample change detector. Tagged samples arrive on a
//   time-multiplexed input. Each channel keeps a stored baseline. A sample
//   whose absolute difference from its channel baseline exceeds THRESH
//   replaces the baseline and pushes a {channel, value, delta} event into a
//   first-word-fall-through event FIFO that is drained with valid/ready.
//
//   Optional build macro DELTA_DEBOUNCE_EN: a hit is only acted on when it
//   follows a previous hit on the same channel (one-sample confirmation).
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high reset
//   smp_valid  : sample present this cycle (always accepted)
//   smp_ch     : sample channel, values >= NCH are ignored
//   smp_data   : sample value
//   evt_valid  : FIFO head holds an event
//   evt_ready  : consumer pops the head when evt_valid && evt_ready
//   evt_ch     : channel of head event
//   evt_data   : new baseline value of head event
//   evt_delta  : absolute difference old vs new of head event
//   evt_any    : sticky per-channel "changed" bitmap
//   ovf        : sticky, an event was dropped on a full FIFO
//   clr        : synchronous clear of evt_any and ovf (a same-edge set wins)
module sensor_delta_monitor #(
  parameter  int DW     = 8,
  parameter  int NCH    = 4,
  parameter  int THRESH = 2,
  parameter  int FDEPTH = 4,
  localparam int CHW    = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           smp_valid,
  input  logic [CHW-1:0] smp_ch,
  input  logic [DW-1:0]  smp_data,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [CHW-1:0] evt_ch,
  output logic [DW-1:0]  evt_data,
  output logic [DW-1:0]  evt_delta,
  output logic [NCH-1:0] evt_any,
  output logic           ovf,
  input  logic           clr
);

  localparam int PW   = $clog2(FDEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [CHW:0]    NCH_L    = (CHW + 1)'(NCH);
  localparam logic [DW-1:0]   THRESH_L = DW'(THRESH);
  localparam logic [CNTW-1:0] FULL_L   = CNTW'(FDEPTH);

  // Stage 1 registers
  logic           s1_v_q, s1_v_d;
  logic [CHW-1:0] s1_ch_q, s1_ch_d;
  logic [DW-1:0]  s1_data_q, s1_data_d;

  // Per-channel baselines
  logic [DW-1:0]  base_q [NCH];
  logic [DW-1:0]  base_d [NCH];

  // Stage 2 combinational
  logic [DW-1:0]  base_rd;
  logic [DW-1:0]  delta;
  logic           hit;
  logic           fire;

  // Event FIFO storage and control
  logic [CHW-1:0] fifo_ch_q    [FDEPTH];
  logic [CHW-1:0] fifo_ch_d    [FDEPTH];
  logic [DW-1:0]  fifo_data_q  [FDEPTH];
  logic [DW-1:0]  fifo_data_d  [FDEPTH];
  logic [DW-1:0]  fifo_delta_q [FDEPTH];
  logic [DW-1:0]  fifo_delta_d [FDEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] keep_cnt;
  logic           pop;
  logic           full;
  logic           push;
  logic           drop;

  // Registered head copy
  logic [CHW-1:0] evt_ch_q, evt_ch_d;
  logic [DW-1:0]  evt_data_q, evt_data_d;
  logic [DW-1:0]  evt_delta_q, evt_delta_d;

  // Sticky status
  logic [NCH-1:0] evt_any_q, evt_any_d;
  logic           ovf_q, ovf_d;

  // ---------------------------------------------------------------- stage 1
  always_comb begin
    s1_v_d    = smp_valid && ({1'b0, smp_ch} < NCH_L);
    s1_ch_d   = s1_ch_q;
    s1_data_d = s1_data_q;
    if (s1_v_d) begin
      s1_ch_d   = smp_ch;
      s1_data_d = smp_data;
    end
  end

  // ---------------------------------------------------------------- stage 2
  // Baseline writes land on the edge after the read, so a back-to-back
  // sample on the same channel naturally sees the updated baseline.
  always_comb begin
    base_rd = base_q[s1_ch_q];
    if (s1_data_q >= base_rd) begin
      delta = s1_data_q - base_rd;
    end else begin
      delta = base_rd - s1_data_q;
    end
    hit = s1_v_q && (delta > THRESH_L);
  end

`ifdef DELTA_DEBOUNCE_EN
  logic [NCH-1:0] pend_q, pend_d;

  // A first hit arms the channel, a second consecutive hit fires and
  // disarms it; any non-hit sample on the channel disarms it.
  always_comb begin
    pend_d = pend_q;
    if (s1_v_q) begin
      pend_d[s1_ch_q] = hit && !pend_q[s1_ch_q];
    end
    fire = hit && pend_q[s1_ch_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  always_comb begin
    fire = hit;
  end
`endif

  // ---------------------------------------------------------- baseline/status
  always_comb begin
    base_d    = base_q;
    evt_any_d = clr ? '0 : evt_any_q;
    ovf_d     = ovf_q && !clr;
    if (fire) begin
      base_d[s1_ch_q]    = s1_data_q;
      evt_any_d[s1_ch_q] = 1'b1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------- FIFO
  always_comb begin
    pop      = (cnt_q != '0) && evt_ready;
    full     = (cnt_q == FULL_L);
    push     = fire && (!full || pop);
    drop     = fire && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CNTW'(push) - CNTW'(pop);
    keep_cnt = cnt_q - CNTW'(pop);

    fifo_ch_d    = fifo_ch_q;
    fifo_data_d  = fifo_data_q;
    fifo_delta_d = fifo_delta_q;
    if (push) begin
      fifo_ch_d[wr_ptr_q]    = s1_ch_q;
      fifo_data_d[wr_ptr_q]  = s1_data_q;
      fifo_delta_d[wr_ptr_q] = delta;
    end
  end

  // The head is mirrored in registers so that evt_* keep the last popped
  // event while the FIFO is empty. Next head: an older surviving entry if
  // any remain, else the entry being pushed, else hold.
  always_comb begin
    evt_ch_d    = evt_ch_q;
    evt_data_d  = evt_data_q;
    evt_delta_d = evt_delta_q;
    if (keep_cnt != '0) begin
      evt_ch_d    = fifo_ch_q[rd_ptr_d];
      evt_data_d  = fifo_data_q[rd_ptr_d];
      evt_delta_d = fifo_delta_q[rd_ptr_d];
    end else if (push) begin
      evt_ch_d    = s1_ch_q;
      evt_data_d  = s1_data_q;
      evt_delta_d = delta;
    end
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q       <= 1'b0;
      s1_ch_q      <= '0;
      s1_data_q    <= '0;
      base_q       <= '{default: '0};
      fifo_ch_q    <= '{default: '0};
      fifo_data_q  <= '{default: '0};
      fifo_delta_q <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      evt_ch_q     <= '0;
      evt_data_q   <= '0;
      evt_delta_q  <= '0;
      evt_any_q    <= '0;
      ovf_q        <= 1'b0;
    end else begin
      s1_v_q       <= s1_v_d;
      s1_ch_q      <= s1_ch_d;
      s1_data_q    <= s1_data_d;
      base_q       <= base_d;
      fifo_ch_q    <= fifo_ch_d;
      fifo_data_q  <= fifo_data_d;
      fifo_delta_q <= fifo_delta_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      evt_ch_q     <= evt_ch_d;
      evt_data_q   <= evt_data_d;
      evt_delta_q  <= evt_delta_d;
      evt_any_q    <= evt_any_d;
      ovf_q        <= ovf_d;
    end
  end

  // ----------------------------------------------------------------- outputs
  always_comb begin
    evt_valid = (cnt_q != '0);
    evt_ch    = evt_ch_q;
    evt_data  = evt_data_q;
    evt_delta = evt_delta_q;
    evt_any   = evt_any_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_sensor_delta_monitor.sv
// tb_sensor_delta_monitor
//   Directed, table-driven bench for sensor_delta_monitor with NCH=5 (not a
//   power of two, so channel index 5 is an ignorable out-of-range tag),
//   DW=8, THRESH=2, FDEPTH=4.
module tb_sensor_delta_monitor;

  localparam int DW     = 8;
  localparam int NCH    = 5;
  localparam int THRESH = 2;
  localparam int FDEPTH = 4;
  localparam int CHW    = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           smp_valid;
  logic [CHW-1:0] smp_ch;
  logic [DW-1:0]  smp_data;
  logic           evt_valid;
  logic           evt_ready;
  logic [CHW-1:0] evt_ch;
  logic [DW-1:0]  evt_data;
  logic [DW-1:0]  evt_delta;
  logic [NCH-1:0] evt_any;
  logic           ovf;
  logic           clr;

  int n_tests = 0;
  int n_fail  = 0;

  sensor_delta_monitor #(
    .DW(DW),
    .NCH(NCH),
    .THRESH(THRESH),
    .FDEPTH(FDEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .smp_valid(smp_valid),
    .smp_ch(smp_ch),
    .smp_data(smp_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch(evt_ch),
    .evt_data(evt_data),
    .evt_delta(evt_delta),
    .evt_any(evt_any),
    .ovf(ovf),
    .clr(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           v;
    logic [CHW-1:0] ch;
    logic [DW-1:0]  d;
    logic           rdy;
    logic           c;
    logic           ev;
    logic [CHW-1:0] ech;
    logic [DW-1:0]  edata;
    logic [DW-1:0]  edelta;
    logic [NCH-1:0] eany;
    logic           eovf;
  } vec_t;

  vec_t tbl [35];

  // {valid, ch, data, delta, any, ovf}
  function automatic logic [25:0] pk(input logic v, input logic [2:0] ch,
                                     input logic [7:0] d, input logic [7:0] dl,
                                     input logic [4:0] an, input logic o);
    return {v, ch, d, dl, an, o};
  endfunction

  function automatic vec_t mk(input logic v, input logic [2:0] ch,
                              input logic [7:0] d, input logic rdy,
                              input logic c, input logic ev,
                              input logic [2:0] ech, input logic [7:0] edata,
                              input logic [7:0] edelta, input logic [4:0] eany,
                              input logic eovf);
    vec_t r;
    r.v = v; r.ch = ch; r.d = d; r.rdy = rdy; r.c = c;
    r.ev = ev; r.ech = ech; r.edata = edata; r.edelta = edelta;
    r.eany = eany; r.eovf = eovf;
    return r;
  endfunction

  task automatic check(input string name, input logic [25:0] exp);
    logic [25:0] act;
    act = {evt_valid, evt_ch, evt_data, evt_delta, evt_any, ovf};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b ch=%0d data=%0d delta=%0d any=%b ovf=%b, expected v=%b ch=%0d data=%0d delta=%0d any=%b ovf=%b",
               name, act[25], act[24:22], act[21:14], act[13:6], act[5:1], act[0],
               exp[25], exp[24:22], exp[21:14], exp[13:6], exp[5:1], exp[0]);
    end
  endtask

  // Drive inputs for one cycle, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [2:0] ch, input logic [7:0] d,
                      input logic rdy, input logic c);
    smp_valid = v;
    smp_ch    = ch;
    smp_data  = d;
    evt_ready = rdy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    smp_valid = 1'b0;
    smp_ch    = '0;
    smp_data  = '0;
    evt_ready = 1'b0;
    clr       = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", pk(0, 0, 0, 0, 5'b00000, 0));
    reset = 1'b0;
  endtask

  initial begin
    //            v ch  d    rdy clr  ev ech edata edelta eany    eovf
    tbl[0]  = mk(1, 0,  5,   0, 0,   0, 0,  0,   0,   5'b00000, 0);
    tbl[1]  = mk(0, 0,  0,   0, 0,   1, 0,  5,   5,   5'b00001, 0);
    tbl[2]  = mk(0, 0,  0,   1, 0,   0, 0,  5,   5,   5'b00001, 0);
    tbl[3]  = mk(1, 1,  100, 1, 0,   0, 0,  5,   5,   5'b00001, 0);
    tbl[4]  = mk(1, 1,  102, 1, 0,   1, 1,  100, 100, 5'b00011, 0);
    tbl[5]  = mk(1, 1,  98,  1, 0,   0, 1,  100, 100, 5'b00011, 0);
    tbl[6]  = mk(1, 1,  97,  1, 0,   0, 1,  100, 100, 5'b00011, 0);
    tbl[7]  = mk(0, 0,  0,   0, 0,   1, 1,  97,  3,   5'b00011, 0);
    tbl[8]  = mk(0, 0,  0,   1, 0,   0, 1,  97,  3,   5'b00011, 0);
    tbl[9]  = mk(1, 2,  200, 1, 0,   0, 1,  97,  3,   5'b00011, 0);
    tbl[10] = mk(1, 2,  10,  1, 0,   1, 2,  200, 200, 5'b00111, 0);
    tbl[11] = mk(0, 0,  0,   1, 0,   1, 2,  10,  190, 5'b00111, 0);
    tbl[12] = mk(0, 0,  0,   1, 0,   0, 2,  10,  190, 5'b00111, 0);
    tbl[13] = mk(1, 0,  50,  0, 0,   0, 2,  10,  190, 5'b00111, 0);
    tbl[14] = mk(1, 1,  20,  0, 0,   1, 0,  50,  45,  5'b00111, 0);
    tbl[15] = mk(1, 2,  30,  0, 0,   1, 0,  50,  45,  5'b00111, 0);
    tbl[16] = mk(1, 3,  40,  0, 0,   1, 0,  50,  45,  5'b00111, 0);
    tbl[17] = mk(1, 4,  60,  0, 0,   1, 0,  50,  45,  5'b01111, 0);
    tbl[18] = mk(0, 0,  0,   0, 0,   1, 0,  50,  45,  5'b11111, 1);
    tbl[19] = mk(0, 0,  0,   1, 0,   1, 1,  20,  77,  5'b11111, 1);
    tbl[20] = mk(0, 0,  0,   1, 0,   1, 2,  30,  20,  5'b11111, 1);
    tbl[21] = mk(0, 0,  0,   1, 0,   1, 3,  40,  40,  5'b11111, 1);
    tbl[22] = mk(0, 0,  0,   1, 0,   0, 3,  40,  40,  5'b11111, 1);
    tbl[23] = mk(0, 0,  0,   1, 1,   0, 3,  40,  40,  5'b00000, 0);
    tbl[24] = mk(1, 0,  0,   0, 0,   0, 3,  40,  40,  5'b00000, 0);
    tbl[25] = mk(1, 1,  0,   0, 0,   1, 0,  0,   50,  5'b00001, 0);
    tbl[26] = mk(1, 2,  0,   0, 0,   1, 0,  0,   50,  5'b00011, 0);
    tbl[27] = mk(1, 3,  0,   0, 0,   1, 0,  0,   50,  5'b00111, 0);
    tbl[28] = mk(1, 4,  0,   0, 0,   1, 0,  0,   50,  5'b01111, 0);
    tbl[29] = mk(1, 5,  99,  1, 0,   1, 1,  0,   20,  5'b11111, 0);
    tbl[30] = mk(0, 0,  0,   0, 0,   1, 1,  0,   20,  5'b11111, 0);
    tbl[31] = mk(0, 0,  0,   1, 0,   1, 2,  0,   30,  5'b11111, 0);
    tbl[32] = mk(0, 0,  0,   1, 0,   1, 3,  0,   40,  5'b11111, 0);
    tbl[33] = mk(0, 0,  0,   1, 0,   1, 4,  0,   60,  5'b11111, 0);
    tbl[34] = mk(0, 0,  0,   1, 0,   0, 4,  0,   60,  5'b11111, 0);

    do_reset();

`ifdef DELTA_DEBOUNCE_EN
    // Two consecutive hits on ch3: only the second produces an event.
    step(1, 3, 50, 0, 0);
    check("db_first", pk(0, 0, 0, 0, 5'b00000, 0));
    step(1, 3, 51, 0, 0);
    check("db_armed", pk(0, 0, 0, 0, 5'b00000, 0));
    step(0, 0, 0, 0, 0);
    check("db_fire", pk(1, 3, 51, 51, 5'b01000, 0));
    step(0, 0, 0, 1, 0);
    check("db_pop", pk(0, 3, 51, 51, 5'b01000, 0));

    // 50, 0, 50 never confirms; a following 51 confirms the last 50.
    do_reset();
    step(1, 3, 50, 0, 0);
    check("db_seq_a", pk(0, 0, 0, 0, 5'b00000, 0));
    step(1, 3, 0, 0, 0);
    check("db_seq_b", pk(0, 0, 0, 0, 5'b00000, 0));
    step(1, 3, 50, 0, 0);
    check("db_seq_c", pk(0, 0, 0, 0, 5'b00000, 0));
    step(1, 3, 51, 0, 0);
    check("db_seq_d", pk(0, 0, 0, 0, 5'b00000, 0));
    step(0, 0, 0, 0, 0);
    check("db_seq_fire", pk(1, 3, 51, 51, 5'b01000, 0));

    // Reset with an armed channel discards the FIFO and the armed state.
    step(1, 2, 40, 0, 0);
    step(0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 check("db_async_rst", pk(0, 0, 0, 0, 5'b00000, 0));
    @(posedge clk);
    #1 reset = 1'b0;
    step(1, 2, 41, 0, 0);
    step(0, 0, 0, 0, 0);
    check("db_rst_disarm", pk(0, 0, 0, 0, 5'b00000, 0));
    step(1, 2, 42, 0, 0);
    step(0, 0, 0, 0, 0);
    check("db_rst_base0", pk(1, 2, 42, 42, 5'b00100, 0));
`else
    for (int unsigned i = 0; i < 35; i++) begin
      step(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].rdy, tbl[i].c);
      check($sformatf("vec%0d", i),
            pk(tbl[i].ev, tbl[i].ech, tbl[i].edata, tbl[i].edelta,
               tbl[i].eany, tbl[i].eovf));
    end

    // Reset mid-stream: FIFO entry and in-flight sample both discarded,
    // baselines return to 0.
    step(1, 2, 77, 0, 0);
    step(1, 1, 88, 0, 0);
    check("pre_rst_evt", pk(1, 2, 77, 77, 5'b11111, 0));
    smp_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_rst", pk(0, 0, 0, 0, 5'b00000, 0));
    @(posedge clk);
    #1 reset = 1'b0;
    step(0, 0, 0, 0, 0);
    check("rst_inflight_gone", pk(0, 0, 0, 0, 5'b00000, 0));
    step(1, 2, 5, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_base_zero", pk(1, 2, 5, 5, 5'b00100, 0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
